// File: rtl/serial_subtractor_if.sv
// Operand/result bundle for serial_subtractor. Defining SERIAL_SUB_FLAGS_EN
// adds the zero/ovf result flags to the bundle.
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bw_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bw_out;
`ifdef SERIAL_SUB_FLAGS_EN
  logic             zero;
  logic             ovf;

  modport master (output start, a, b, bw_in,
                  input  busy, done, diff, bw_out, zero, ovf);
  modport slave  (input  start, a, b, bw_in,
                  output busy, done, diff, bw_out, zero, ovf);
`else
  modport master (output start, a, b, bw_in,
                  input  busy, done, diff, bw_out);
  modport slave  (input  start, a, b, bw_in,
                  output busy, done, diff, bw_out);
`endif
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial a - b - bw_in, LSB first, one full-subtractor cell per clock.
// Optional zero/ovf flags are enabled by SERIAL_SUB_FLAGS_EN.
module serial_subtractor #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  serial_subtractor_if.slave bus
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d, diff_q, diff_d;
  logic             br_q, br_d, bw_out_q, bw_out_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             d_bit, br_next;
  logic [WIDTH-1:0] res_nxt;
`ifdef SERIAL_SUB_FLAGS_EN
  logic             amsb_q, amsb_d, bmsb_q, bmsb_d;
  logic             zero_q, zero_d, ovf_q, ovf_d;
`endif

  // Full-subtractor cell on the current LSBs.
  assign d_bit   = a_q[0] ^ b_q[0] ^ br_q;
  assign br_next = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
  assign res_nxt = {d_bit, res_q[WIDTH-1:1]};

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    diff_d   = diff_q;
    br_d     = br_q;
    bw_out_d = bw_out_q;
    cnt_d    = cnt_q;
`ifdef SERIAL_SUB_FLAGS_EN
    amsb_d   = amsb_q;
    bmsb_d   = bmsb_q;
    zero_d   = zero_q;
    ovf_d    = ovf_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          a_d     = bus.a;
          b_d     = bus.b;
          br_d    = bus.bw_in;
          cnt_d   = '0;
          state_d = S_SHIFT;
`ifdef SERIAL_SUB_FLAGS_EN
          amsb_d  = bus.a[WIDTH-1];
          bmsb_d  = bus.b[WIDTH-1];
`endif
        end
      end
      S_SHIFT: begin
        res_d = res_nxt;
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        br_d  = br_next;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          // Published result only changes here, so it stays stable across the next op.
          state_d  = S_DONE;
          diff_d   = res_nxt;
          bw_out_d = br_next;
`ifdef SERIAL_SUB_FLAGS_EN
          zero_d   = (res_nxt == '0);
          ovf_d    = (amsb_q != bmsb_q) && (res_nxt[WIDTH-1] != amsb_q);
`endif
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      diff_q   <= '0;
      br_q     <= 1'b0;
      bw_out_q <= 1'b0;
      cnt_q    <= '0;
`ifdef SERIAL_SUB_FLAGS_EN
      amsb_q   <= 1'b0;
      bmsb_q   <= 1'b0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      diff_q   <= diff_d;
      br_q     <= br_d;
      bw_out_q <= bw_out_d;
      cnt_q    <= cnt_d;
`ifdef SERIAL_SUB_FLAGS_EN
      amsb_q   <= amsb_d;
      bmsb_q   <= bmsb_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign bus.busy   = (state_q == S_SHIFT);
  assign bus.done   = (state_q == S_DONE);
  assign bus.diff   = diff_q;
  assign bus.bw_out = bw_out_q;
`ifdef SERIAL_SUB_FLAGS_EN
  assign bus.zero   = zero_q;
  assign bus.ovf    = ovf_q;
`endif
endmodule
